// File: rtl/y86_decode_execute_stage.sv
// Y86-64 D/E pipeline registers with the execute-stage ALU, branch/cmov
// condition evaluation and the condition-code register.
module y86_decode_execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        d_stall,
  input  logic        d_bubble,
  input  logic        e_bubble,
  input  logic        cc_inhibit,
  input  logic [63:0] rf_valA,
  input  logic [63:0] rf_valB,
  output logic [2:0]  d_stat,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [3:0]  d_rA,
  output logic [3:0]  d_rB,
  output logic [63:0] d_valC,
  output logic [63:0] d_valP,
  output logic [2:0]  e_stat,
  output logic [3:0]  e_icode,
  output logic [3:0]  e_ifun,
  output logic [3:0]  e_rA,
  output logic [3:0]  e_rB,
  output logic [63:0] e_valC,
  output logic [63:0] e_valA,
  output logic [63:0] e_valB,
  output logic [63:0] e_valP,
  output logic [63:0] e_valE,
  output logic        e_cnd,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  typedef enum logic [3:0] {
    I_HALT  = 4'h0, I_NOP  = 4'h1, I_CMOV = 4'h2, I_IRMOV = 4'h3,
    I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OP  = 4'h6, I_JXX   = 4'h7,
    I_CALL  = 4'h8, I_RET  = 4'h9, I_PUSH = 4'hA, I_POP   = 4'hB
  } icode_e;

  localparam logic [2:0] STAT_AOK = 3'b001;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
  } dreg_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valA, valB, valP;
  } ereg_t;

  localparam dreg_t D_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                                 rA: 4'hF, rB: 4'hF, valC: '0, valP: '0};
  localparam ereg_t E_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                                 rA: 4'hF, rB: 4'hF, valC: '0, valA: '0,
                                 valB: '0, valP: '0};

  dreg_t       r_d;
  ereg_t       r_e;
  logic        r_zf, r_sf, r_of;
  logic [63:0] w_valE;
  logic        w_of;
  logic        w_cnd;
  logic        w_sxo;
  logic        w_cc_we;

  // Stall has priority over bubble on the D register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d <= D_BUBBLE;
    end else if (d_stall) begin
      r_d <= r_d;
    end else if (d_bubble) begin
      r_d <= D_BUBBLE;
    end else begin
      r_d <= '{stat: f_stat, icode: f_icode, ifun: f_ifun, rA: f_rA,
               rB: f_rB, valC: f_valC, valP: f_valP};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e <= E_BUBBLE;
    end else if (e_bubble) begin
      r_e <= E_BUBBLE;
    end else begin
      r_e <= '{stat: r_d.stat, icode: r_d.icode, ifun: r_d.ifun, rA: r_d.rA,
               rB: r_d.rB, valC: r_d.valC, valA: rf_valA, valB: rf_valB,
               valP: r_d.valP};
    end
  end

  always_comb begin
    w_valE = '0;
    w_of   = 1'b0;
    case (r_e.icode)
      I_CMOV:          w_valE = r_e.valA;
      I_IRMOV:         w_valE = r_e.valC;
      I_RMMOV, I_MRMOV: w_valE = r_e.valB + r_e.valC;
      I_OP: begin
        case (r_e.ifun)
          4'h0: begin
            w_valE = r_e.valB + r_e.valA;
            w_of   = (r_e.valA[63] == r_e.valB[63]) && (w_valE[63] != r_e.valB[63]);
          end
          4'h1: begin
            w_valE = r_e.valB - r_e.valA;
            w_of   = (r_e.valA[63] != r_e.valB[63]) && (w_valE[63] != r_e.valB[63]);
          end
          4'h2:    w_valE = r_e.valB & r_e.valA;
          4'h3:    w_valE = r_e.valB ^ r_e.valA;
          default: w_valE = '0;
        endcase
      end
      I_CALL, I_PUSH:  w_valE = r_e.valB - 64'd8;
      I_RET, I_POP:    w_valE = r_e.valB + 64'd8;
      default:         w_valE = '0;
    endcase
  end

  // Conditions use the CC as it stands before this cycle's update.
  always_comb begin
    w_sxo = r_sf ^ r_of;
    w_cnd = 1'b0;
    if (r_e.icode == I_CMOV || r_e.icode == I_JXX) begin
      case (r_e.ifun)
        4'h0:    w_cnd = 1'b1;
        4'h1:    w_cnd = w_sxo | r_zf;
        4'h2:    w_cnd = w_sxo;
        4'h3:    w_cnd = r_zf;
        4'h4:    w_cnd = ~r_zf;
        4'h5:    w_cnd = ~w_sxo;
        4'h6:    w_cnd = ~w_sxo & ~r_zf;
        default: w_cnd = 1'b0;
      endcase
    end
  end

  assign w_cc_we = (r_e.icode == I_OP) && (r_e.stat == STAT_AOK) && !cc_inhibit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_cc_we) begin
      r_zf <= (w_valE == '0);
      r_sf <= w_valE[63];
      r_of <= w_of;
    end
  end

  assign d_stat  = r_d.stat;
  assign d_icode = r_d.icode;
  assign d_ifun  = r_d.ifun;
  assign d_rA    = r_d.rA;
  assign d_rB    = r_d.rB;
  assign d_valC  = r_d.valC;
  assign d_valP  = r_d.valP;
  assign e_stat  = r_e.stat;
  assign e_icode = r_e.icode;
  assign e_ifun  = r_e.ifun;
  assign e_rA    = r_e.rA;
  assign e_rB    = r_e.rB;
  assign e_valC  = r_e.valC;
  assign e_valA  = r_e.valA;
  assign e_valB  = r_e.valB;
  assign e_valP  = r_e.valP;
  assign e_valE  = w_valE;
  assign e_cnd   = w_cnd;
  assign zf      = r_zf;
  assign sf      = r_sf;
  assign of      = r_of;

endmodule

// File: tb/tb_y86_decode_execute_stage.sv
// Bench for y86_decode_execute_stage: directed vector table, stall/bubble/reset
// sequences, then random traffic checked against a transaction-level model.
module tb_y86_decode_execute_stage;

  logic        clk, rst;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic        d_stall, d_bubble, e_bubble, cc_inhibit;
  logic [63:0] rf_valA, rf_valB;
  logic [2:0]  d_stat, e_stat;
  logic [3:0]  d_icode, d_ifun, d_rA, d_rB, e_icode, e_ifun, e_rA, e_rB;
  logic [63:0] d_valC, d_valP, e_valC, e_valA, e_valB, e_valP, e_valE;
  logic        e_cnd, zf, sf, of;

  int checks = 0;
  int errors = 0;

  y86_decode_execute_stage dut (
    .clk(clk), .rst(rst), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
    .d_stall(d_stall), .d_bubble(d_bubble), .e_bubble(e_bubble),
    .cc_inhibit(cc_inhibit), .rf_valA(rf_valA), .rf_valB(rf_valB),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
    .d_valC(d_valC), .d_valP(d_valP), .e_stat(e_stat), .e_icode(e_icode),
    .e_ifun(e_ifun), .e_rA(e_rA), .e_rB(e_rB), .e_valC(e_valC), .e_valA(e_valA),
    .e_valB(e_valB), .e_valP(e_valP), .e_valE(e_valE), .e_cnd(e_cnd),
    .zf(zf), .sf(sf), .of(of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model of the two pipeline registers and the CC.
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valA, valB, valP;
  } instr_t;

  instr_t md, me;
  logic   mz, ms, mo;

  function automatic instr_t nop_instr();
    instr_t n;
    n = '0;
    n.stat = 3'b001; n.icode = 4'h1; n.rA = 4'hF; n.rB = 4'hF;
    return n;
  endfunction

  function automatic logic [63:0] ref_valE(input instr_t t);
    case (t.icode)
      4'h2: return t.valA;
      4'h3: return t.valC;
      4'h4, 4'h5: return t.valB + t.valC;
      4'h6: begin
        if (t.ifun == 0) return t.valB + t.valA;
        if (t.ifun == 1) return t.valB - t.valA;
        if (t.ifun == 2) return t.valB & t.valA;
        if (t.ifun == 3) return t.valB ^ t.valA;
        return 64'd0;
      end
      4'h8, 4'hA: return t.valB - 64'd8;
      4'h9, 4'hB: return t.valB + 64'd8;
      default: return 64'd0;
    endcase
  endfunction

  // Overflow as "the 65-bit signed result does not fit in 64 bits".
  function automatic logic ref_of(input instr_t t);
    logic [64:0] s;
    if (t.icode != 4'h6) return 1'b0;
    if (t.ifun == 0) begin
      s = {t.valB[63], t.valB} + {t.valA[63], t.valA};
      return s[64] ^ s[63];
    end
    if (t.ifun == 1) begin
      s = {t.valB[63], t.valB} - {t.valA[63], t.valA};
      return s[64] ^ s[63];
    end
    return 1'b0;
  endfunction

  function automatic logic ref_cnd(input instr_t t, input logic z, s, o);
    if (t.icode != 4'h2 && t.icode != 4'h7) return 1'b0;
    case (t.ifun)
      4'h0: return 1'b1;
      4'h1: return (s != o) || z;
      4'h2: return s != o;
      4'h3: return z;
      4'h4: return !z;
      4'h5: return s == o;
      4'h6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    md = nop_instr(); me = nop_instr();
    mz = 1'b1; ms = 1'b0; mo = 1'b0;
  endtask

  task automatic tick();
    logic [63:0] v;
    @(posedge clk);
    if (!rst) begin
      if (me.icode == 4'h6 && me.stat == 3'b001 && !cc_inhibit) begin
        v = ref_valE(me);
        mz = (v == 64'd0); ms = v[63]; mo = ref_of(me);
      end
      if (e_bubble) me = nop_instr();
      else begin
        me = md; me.valA = rf_valA; me.valB = rf_valB;
      end
      if (!d_stall) begin
        if (d_bubble) md = nop_instr();
        else md = '{f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, 64'd0, 64'd0, f_valP};
      end
    end
    #1;
  endtask

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " D"}, {d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP},
          {md.stat, md.icode, md.ifun, md.rA, md.rB, md.valC, md.valP});
    check({tag, " E"}, {e_stat, e_icode, e_ifun, e_rA, e_rB, e_valC, e_valA, e_valB, e_valP}, me);
    check({tag, " valE"}, e_valE, ref_valE(me));
    check({tag, " cnd"}, e_cnd, ref_cnd(me, mz, ms, mo));
    check({tag, " cc"}, {zf, sf, of}, {mz, ms, mo});
  endtask

  task automatic drive_fetch(input logic [2:0] st, input logic [3:0] ic, fn, input logic [63:0] c);
    f_stat = st; f_icode = ic; f_ifun = fn; f_rA = 4'h0; f_rB = 4'h2;
    f_valC = c; f_valP = 64'h40;
  endtask

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun;
    logic [63:0] valC, valA, valB;
    logic        inh;
    logic [63:0] exp_valE;
    logic        exp_cnd;
    logic [2:0]  exp_zso;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{3'b001, 4'h3, 4'h0, 64'd10, 64'd0, 64'd0, 1'b0, 64'd10, 1'b0, 3'b100};
    tbl[1]  = '{3'b001, 4'h6, 4'h0, 64'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 3'b011};
    tbl[2]  = '{3'b001, 4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 1'b0, 64'd0, 1'b0, 3'b100};
    tbl[3]  = '{3'b001, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 3'b100};
    tbl[4]  = '{3'b001, 4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 3'b100};
    tbl[5]  = '{3'b001, 4'h8, 4'h0, 64'd0, 64'd0, 64'h100, 1'b0, 64'hF8, 1'b0, 3'b100};
    tbl[6]  = '{3'b001, 4'hB, 4'h0, 64'd0, 64'd0, 64'hF8, 1'b0, 64'h100, 1'b0, 3'b100};
    tbl[7]  = '{3'b001, 4'h6, 4'h2, 64'd0, 64'hFF, 64'h0F, 1'b1, 64'h0F, 1'b0, 3'b100};
    tbl[8]  = '{3'b001, 4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b010};
    tbl[9]  = '{3'b001, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 3'b010};
    tbl[10] = '{3'b001, 4'h2, 4'h6, 64'd0, 64'h1234, 64'd0, 1'b0, 64'h1234, 1'b0, 3'b010};
    tbl[11] = '{3'b001, 4'h6, 4'h7, 64'd0, 64'd3, 64'd4, 1'b0, 64'd0, 1'b0, 3'b100};
    tbl[12] = '{3'b001, 4'h4, 4'h0, 64'd8, 64'd0, 64'h10, 1'b0, 64'h18, 1'b0, 3'b100};
    tbl[13] = '{3'b001, 4'h6, 4'h1, 64'd0, 64'h8000_0000_0000_0000, 64'd1, 1'b0,
                64'h8000_0000_0000_0001, 1'b0, 3'b011};
    tbl[14] = '{3'b001, 4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 3'b011};
    tbl[15] = '{3'b001, 4'h7, 4'h9, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 3'b011};
    tbl[16] = '{3'b010, 4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 3'b011};
    tbl[17] = '{3'b001, 4'h6, 4'h3, 64'd0, 64'hF0, 64'hFF, 1'b0, 64'h0F, 1'b0, 3'b000};
    tbl[18] = '{3'b001, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 3'b000};
    tbl[19] = '{3'b001, 4'h2, 4'h0, 64'd0, 64'h77, 64'd0, 1'b0, 64'h77, 1'b1, 3'b000};

    rst = 1'b1; d_stall = 1'b0; d_bubble = 1'b0; e_bubble = 1'b0; cc_inhibit = 1'b0;
    rf_valA = '0; rf_valB = '0;
    drive_fetch(3'b001, 4'h1, 4'h0, 64'd0);
    model_reset();
    #2;
    check("reset d_icode", d_icode, 4'h1);
    check("reset e_icode", e_icode, 4'h1);
    check("reset rA/rB", {d_rA, d_rB, e_rA, e_rB}, 16'hFFFF);
    check("reset cc", {zf, sf, of}, 3'b100);
    check("reset valE/cnd", {e_valE, e_cnd}, 65'd0);
    @(negedge clk); rst = 1'b0;

    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      drive_fetch(tbl[i].stat, tbl[i].icode, tbl[i].ifun, tbl[i].valC);
      cc_inhibit = tbl[i].inh;
      tick();
      check($sformatf("row%0d d_icode", i), d_icode, tbl[i].icode);
      @(negedge clk);
      drive_fetch(3'b001, 4'h1, 4'h0, 64'd0);
      rf_valA = tbl[i].valA; rf_valB = tbl[i].valB;
      tick();
      check($sformatf("row%0d valE", i), e_valE, tbl[i].exp_valE);
      check($sformatf("row%0d cnd", i), e_cnd, tbl[i].exp_cnd);
      @(negedge clk);
      tick();
      check($sformatf("row%0d cc", i), {zf, sf, of}, tbl[i].exp_zso);
    end
    cc_inhibit = 1'b0;

    // D stall holds across edges, stall beats bubble, then bubble and E bubble.
    @(negedge clk); drive_fetch(3'b001, 4'h3, 4'h0, 64'h55); tick();
    @(negedge clk); d_stall = 1'b1; drive_fetch(3'b001, 4'h4, 4'h1, 64'h66);
    tick(); tick();
    check("stall hold", {d_icode, d_valC}, {4'h3, 64'h55});
    @(negedge clk); d_bubble = 1'b1; tick();
    check("stall+bubble hold", {d_icode, d_valC}, {4'h3, 64'h55});
    @(negedge clk); d_stall = 1'b0; tick();
    check("d bubble", {d_icode, d_rA, d_valC}, {4'h1, 4'hF, 64'h0});
    @(negedge clk); d_bubble = 1'b0; e_bubble = 1'b1; tick();
    check("e bubble", {e_icode, e_valE}, {4'h1, 64'h0});
    @(negedge clk); e_bubble = 1'b0; drive_fetch(3'b001, 4'h3, 4'h0, 64'h99);
    tick(); tick();
    check("flow e_valE", {e_icode, e_valE}, {4'h3, 64'h99});

    // Mid-operation async reset, then normal load on the first edge after release.
    @(negedge clk); rst = 1'b1; #1; model_reset();
    check("mid reset", {d_icode, e_icode, zf, sf, of}, {4'h1, 4'h1, 3'b100});
    @(negedge clk); rst = 1'b0; drive_fetch(3'b001, 4'h5, 4'h0, 64'h20); tick();
    check("post reset load", d_icode, 4'h5);
    compare_all("post reset");

    for (int unsigned n = 0; n < 300; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 5))
        0: f_stat = 3'b010;
        1: f_stat = 3'b100;
        default: f_stat = 3'b001;
      endcase
      f_icode = 4'($urandom_range(0, 11));
      f_ifun  = 4'($urandom_range(0, 7));
      f_rA = 4'($urandom); f_rB = 4'($urandom);
      f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: begin rf_valA = {$urandom, $urandom}; rf_valB = {$urandom, $urandom}; end
        1: begin rf_valA = 64'($urandom_range(0, 3)); rf_valB = rf_valA; end
        2: begin rf_valA = {1'b1, 63'($urandom)}; rf_valB = {1'b1, 63'($urandom)}; end
        default: begin rf_valA = {1'b0, 63'($urandom)} << 30; rf_valB = {2'b01, 62'($urandom)}; end
      endcase
      d_stall    = ($urandom_range(0, 7) == 0);
      d_bubble   = ($urandom_range(0, 7) == 0);
      e_bubble   = ($urandom_range(0, 9) == 0);
      cc_inhibit = ($urandom_range(0, 3) == 0);
      tick();
      compare_all($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
